clk_div_bank: RTL



---
 rtl/clk_div_bank.sv | 119 +++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// Multi-channel 50%-duty clock divider with per-channel tick strobes, glitch-free
// runtime divisor updates at period boundaries, clean start/stop and a global phase-align strobe.
module clk_div_bank #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 24,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  output logic              wr_err,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic wr_ok;

  assign wr_ok = wr_en && (wr_data != '0) && (32'(wr_ch) < NUM_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] half_cur, half_n;
    logic [CNT_W-1:0] pending;
    logic             pend_r;
    logic             clk_r;
    logic             tick_r;
    logic             go;
    logic             wr_hit;

    assign wr_hit = wr_ok && (32'(wr_ch) == 32'(g));

    // A HIGH entry (start, LOW->HIGH, or sync) is the only place a new half-period lands.
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      half_n  = half_cur;
      go      = en[g] && (sync || (state == IDLE) || ((state == LOW) && (cnt == '0)));
      if (go) begin
        if (pend_r) begin
          half_n = pending;
        end
        state_n = HIGH;
        cnt_n   = half_n - CNT_W'(1);
      end else begin
        case (state)
          HIGH: begin
            if (cnt == '0) begin
              state_n = LOW;
              cnt_n   = half_cur - CNT_W'(1);
            end else begin
              cnt_n = cnt - CNT_W'(1);
            end
          end
          LOW: begin
            if (cnt == '0) begin
              state_n = IDLE;
            end else begin
              cnt_n = cnt - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= IDLE;
        cnt      <= '0;
        half_cur <= CNT_W'(DEFAULT_HALF);
        pending  <= CNT_W'(DEFAULT_HALF);
        pend_r   <= 1'b0;
        clk_r    <= 1'b0;
        tick_r   <= 1'b0;
      end else begin
        state    <= state_n;
        cnt      <= cnt_n;
        half_cur <= half_n;
        clk_r    <= (state_n == HIGH);
        tick_r   <= go;
        // A write landing on a boundary edge stays pending for the following period.
        if (wr_hit) begin
          pending <= wr_data;
          pend_r  <= 1'b1;
        end else if (go) begin
          pend_r  <= 1'b0;
        end
      end
    end

    assign clk_out[g] = clk_r;
    assign tick[g]    = tick_r;
    assign pend[g]    = pend_r;
    assign active[g]  = (state != IDLE);
  end

endmodule
